// File: rtl/activation_pkg.sv
// -----------------------------------------------------------------------------
// activation_pkg
//
// Shared types and widths for the activation arbiter slice.
//
//   state_t : arbiter FSM state
//     IDLE  no grant; every routed valid/ready is held low
//     FWD   forward phase of the granted requester (argument -> result)
//     BWD   backward phase of the granted requester (error -> propagate)
//
//   ARG_W / RES_W / ERR_W / PRP_W : payload widths of the four channels
//     (argument, result, error, propagate).
// -----------------------------------------------------------------------------
package activation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2
    } state_t;

    localparam int ARG_W = 16;
    localparam int RES_W = 8;
    localparam int ERR_W = 16;
    localparam int PRP_W = 16;

endpackage : activation_pkg

// File: rtl/activation_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//
// Combinational round-robin search. Returns the first set bit of `request`
// at or above `ptr`, wrapping from N-1 back to 0.
//
// Ports
//   request : N-bit request vector
//   ptr     : index where the search starts (0..N-1)
//   found   : 1 when any request bit is set
//   index   : winning requester index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         request,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] index
);

    localparam int PW = $clog2(N);

    // Walk the N candidates in priority order ptr, ptr+1, ... and keep the
    // first hit. The modulo handles the wrap and non-power-of-two N alike.
    always_comb begin
        int cand;
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && request[cand]) begin
                found = 1'b1;
                index = PW'(cand);
            end
        end
    end

endmodule : rr_picker

// File: rtl/activation_arbiter.sv
// -----------------------------------------------------------------------------
// activation_arbiter
//
// Time-multiplexes one shared sigmoid activation unit among N neuron
// requesters with round-robin fairness. A grant covers a whole transaction:
// argument -> result, and in training also error -> propagate, so the unit's
// internal result/derivative state stays bound to one requester.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holds valid and data stable
// until that transfer; ready may change freely. All routing here is
// combinational from the registered grant, so the arbiter adds no latency
// to any handshake.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   train               : training mode, sampled when a grant is made
//   s_argument_*        : per-requester argument in (data 16 bits/requester)
//   s_result_*          : result out to requesters (data shared, 8 bits)
//   s_error_*           : per-requester backpropagated error in (16 bits each)
//   s_propagate_*       : propagated error out (data shared, 16 bits)
//   m_train             : latched mode to the activation unit (0 in IDLE)
//   m_argument_*        : argument to the activation unit
//   m_result_*          : result from the activation unit
//   m_error_*           : error to the activation unit
//   m_propagate_*       : propagated error from the activation unit
//   debug_state         : current FSM state
//   debug_grant         : registered grant index
//   debug_ptr           : round-robin start pointer for the next arbitration
// -----------------------------------------------------------------------------
module activation_arbiter
    import activation_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 train,

    input  logic [N-1:0]         s_argument_valid,
    input  logic [ARG_W*N-1:0]   s_argument_data,
    output logic [N-1:0]         s_argument_ready,

    output logic [N-1:0]         s_result_valid,
    output logic [RES_W-1:0]     s_result_data,
    input  logic [N-1:0]         s_result_ready,

    input  logic [N-1:0]         s_error_valid,
    input  logic [ERR_W*N-1:0]   s_error_data,
    output logic [N-1:0]         s_error_ready,

    output logic [N-1:0]         s_propagate_valid,
    output logic [PRP_W-1:0]     s_propagate_data,
    input  logic [N-1:0]         s_propagate_ready,

    output logic                 m_train,

    output logic                 m_argument_valid,
    output logic [ARG_W-1:0]     m_argument_data,
    input  logic                 m_argument_ready,

    input  logic                 m_result_valid,
    input  logic [RES_W-1:0]     m_result_data,
    output logic                 m_result_ready,

    output logic                 m_error_valid,
    output logic [ERR_W-1:0]     m_error_data,
    input  logic                 m_error_ready,

    input  logic                 m_propagate_valid,
    input  logic [PRP_W-1:0]     m_propagate_data,
    output logic                 m_propagate_ready,

    output state_t               debug_state,
    output logic [$clog2(N)-1:0] debug_grant,
    output logic [$clog2(N)-1:0] debug_ptr
);

    localparam int PW = $clog2(N);

    state_t        state;
    logic [PW-1:0] grant;
    logic [PW-1:0] ptr;
    logic          mode;
    // Set once the granted argument has transferred, so the same argument
    // cannot be presented to the unit a second time within one grant.
    logic          arg_done;

    logic          pick_found;
    logic [PW-1:0] pick_index;
    logic [PW-1:0] next_ptr;

    logic          in_fwd;
    logic          in_bwd;
    logic          result_hs;
    logic          propagate_hs;

    rr_picker #(.N(N)) u_picker (
        .request (s_argument_valid),
        .ptr     (ptr),
        .found   (pick_found),
        .index   (pick_index)
    );

    assign in_fwd = (state == FWD);
    assign in_bwd = (state == BWD);

    // The pointer moves one past the requester just served, so a requester
    // that re-requests immediately goes to the back of the line.
    assign next_ptr = (int'(grant) == N - 1) ? '0 : grant + PW'(1);

    // Transaction-ending handshakes are qualified by the granted requester's
    // ready, which is exactly what the unit sees on m_*_ready.
    assign result_hs    = in_fwd & m_result_valid & s_result_ready[grant];
    assign propagate_hs = in_bwd & m_propagate_valid & s_propagate_ready[grant];

    // -------------------------------------------------------------------------
    // FSM with grant / pointer / mode registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            mode     <= 1'b0;
            arg_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_index;
                        mode     <= train;
                        arg_done <= 1'b0;
                        state    <= FWD;
                    end
                end
                FWD: begin
                    if (m_argument_valid && m_argument_ready) begin
                        arg_done <= 1'b1;
                    end
                    if (result_hs) begin
                        if (mode) begin
                            state <= BWD;
                        end else begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                        end
                    end
                end
                BWD: begin
                    if (propagate_hs) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The unit picks ERR vs ARG at its result handshake from m_train, so the
    // latched mode is presented for the whole transaction and never in IDLE.
    assign m_train = mode & (state != IDLE);

    // -------------------------------------------------------------------------
    // Channel routing: only the granted requester is ever connected
    // -------------------------------------------------------------------------
    always_comb begin
        s_argument_ready  = '0;
        s_result_valid    = '0;
        s_error_ready     = '0;
        s_propagate_valid = '0;

        // Forward phase: argument towards the unit, result back.
        m_argument_valid = in_fwd & ~arg_done & s_argument_valid[grant];
        m_argument_data  = s_argument_data[int'(grant)*ARG_W +: ARG_W];
        m_result_ready   = in_fwd & s_result_ready[grant];
        if (in_fwd) begin
            s_argument_ready[grant] = m_argument_ready & ~arg_done;
            s_result_valid[grant]   = m_result_valid;
        end
        s_result_data = m_result_data;

        // Backward phase: error towards the unit, propagate back.
        m_error_valid     = in_bwd & s_error_valid[grant];
        m_error_data      = s_error_data[int'(grant)*ERR_W +: ERR_W];
        m_propagate_ready = in_bwd & s_propagate_ready[grant];
        if (in_bwd) begin
            s_error_ready[grant]     = m_error_ready;
            s_propagate_valid[grant] = m_propagate_valid;
        end
        s_propagate_data = m_propagate_data;
    end

    assign debug_state = state;
    assign debug_grant = grant;
    assign debug_ptr   = ptr;

endmodule : activation_arbiter

// File: tb/tb_activation_arbiter.sv
// -----------------------------------------------------------------------------
// tb_activation_arbiter
//
// Directed bench for activation_arbiter with N=4. A small behavioural model of
// the shared activation unit answers on the m_* side: hard sigmoid
// clamp(128 + arg/4) and derivative err * s * (256 - s) / 65536. Expected
// results/propagates are pushed as {requester, data} when stimulus is driven
// and popped when the matching s_* handshake is observed.
// -----------------------------------------------------------------------------
module tb_activation_arbiter;
    import activation_pkg::*;

    localparam int N = 4;
    localparam int W = 20;

    logic             clock;
    logic             reset;
    logic             train;
    logic [N-1:0]     s_argument_valid;
    logic [16*N-1:0]  s_argument_data;
    logic [N-1:0]     s_argument_ready;
    logic [N-1:0]     s_result_valid;
    logic [7:0]       s_result_data;
    logic [N-1:0]     s_result_ready;
    logic [N-1:0]     s_error_valid;
    logic [16*N-1:0]  s_error_data;
    logic [N-1:0]     s_error_ready;
    logic [N-1:0]     s_propagate_valid;
    logic [15:0]      s_propagate_data;
    logic [N-1:0]     s_propagate_ready;
    logic             m_train;
    logic             m_argument_valid;
    logic [15:0]      m_argument_data;
    logic             m_argument_ready;
    logic             m_result_valid;
    logic [7:0]       m_result_data;
    logic             m_result_ready;
    logic             m_error_valid;
    logic [15:0]      m_error_data;
    logic             m_error_ready;
    logic             m_propagate_valid;
    logic [15:0]      m_propagate_data;
    logic             m_propagate_ready;
    state_t           debug_state;
    logic [1:0]       debug_grant;
    logic [1:0]       debug_ptr;

    activation_arbiter #(.N(N)) dut (
        .clock             (clock),
        .reset             (reset),
        .train             (train),
        .s_argument_valid  (s_argument_valid),
        .s_argument_data   (s_argument_data),
        .s_argument_ready  (s_argument_ready),
        .s_result_valid    (s_result_valid),
        .s_result_data     (s_result_data),
        .s_result_ready    (s_result_ready),
        .s_error_valid     (s_error_valid),
        .s_error_data      (s_error_data),
        .s_error_ready     (s_error_ready),
        .s_propagate_valid (s_propagate_valid),
        .s_propagate_data  (s_propagate_data),
        .s_propagate_ready (s_propagate_ready),
        .m_train           (m_train),
        .m_argument_valid  (m_argument_valid),
        .m_argument_data   (m_argument_data),
        .m_argument_ready  (m_argument_ready),
        .m_result_valid    (m_result_valid),
        .m_result_data     (m_result_data),
        .m_result_ready    (m_result_ready),
        .m_error_valid     (m_error_valid),
        .m_error_data      (m_error_data),
        .m_error_ready     (m_error_ready),
        .m_propagate_valid (m_propagate_valid),
        .m_propagate_data  (m_propagate_data),
        .m_propagate_ready (m_propagate_ready),
        .debug_state       (debug_state),
        .debug_grant       (debug_grant),
        .debug_ptr         (debug_ptr)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- activation unit model ----------------
    typedef enum logic [1:0] {AU_ARG, AU_RES, AU_ERR, AU_PRP} au_t;
    au_t        au_state;
    logic [7:0] au_res;
    logic [15:0] au_prp;

    function automatic logic [7:0] sig_model(input logic [15:0] a);
        int v;
        v = 128 + (int'($signed(a)) >>> 2);
        if (v > 255) v = 255;
        if (v < 0) v = 0;
        return v[7:0];
    endfunction

    function automatic logic [15:0] deriv_model(input logic [15:0] e, input logic [7:0] s);
        int p;
        p = (int'($signed(e)) * int'(s) * (256 - int'(s))) >>> 16;
        return p[15:0];
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            au_state <= AU_ARG;
            au_res   <= '0;
            au_prp   <= '0;
        end else begin
            case (au_state)
                AU_ARG: if (m_argument_valid && m_argument_ready) begin
                    au_res   <= sig_model(m_argument_data);
                    au_state <= AU_RES;
                end
                AU_RES: if (m_result_valid && m_result_ready) begin
                    au_state <= m_train ? AU_ERR : AU_ARG;
                end
                AU_ERR: if (m_error_valid && m_error_ready) begin
                    au_prp   <= deriv_model(m_error_data, au_res);
                    au_state <= AU_PRP;
                end
                default: if (m_propagate_valid && m_propagate_ready) begin
                    au_state <= AU_ARG;
                end
            endcase
        end
    end

    assign m_argument_ready  = (au_state == AU_ARG);
    assign m_result_valid    = (au_state == AU_RES);
    assign m_result_data     = au_res;
    assign m_error_ready     = (au_state == AU_ERR);
    assign m_propagate_valid = (au_state == AU_PRP);
    assign m_propagate_data  = au_prp;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_res_q[$];
    logic [W-1:0] exp_prp_q[$];
    int           grant_log[$];
    int           hs_cyc[$];
    int           n_cmp;
    int           n_bad;
    int           cyc;
    logic [N-1:0] keep;

    function automatic logic [W-1:0] pk(input int idx, input logic [15:0] d);
        return {idx[3:0], d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: observe handshakes, cross the rising edge,
    // retire transferred requester valids, return at the next falling edge.
    task automatic step();
        logic [N-1:0] ahs;
        logic [N-1:0] ehs;
        logic [W-1:0] e;
        #1;
        ahs = s_argument_valid & s_argument_ready;
        ehs = s_error_valid & s_error_ready;
        chk("arg_ready_onehot", 32'($countones(s_argument_ready) <= 1), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (ahs[i]) begin
                grant_log.push_back(i);
                hs_cyc.push_back(cyc);
            end
            if (s_result_valid[i] && s_result_ready[i]) begin
                if (exp_res_q.size() == 0) begin
                    chk("res_unexpected", 32'(exp_res_q.size()), 32'd1);
                end else begin
                    e = exp_res_q.pop_front();
                    chk("result", 32'(pk(i, {8'h00, s_result_data})), 32'(e));
                end
            end
            if (s_propagate_valid[i] && s_propagate_ready[i]) begin
                if (exp_prp_q.size() == 0) begin
                    chk("prp_unexpected", 32'(exp_prp_q.size()), 32'd1);
                end else begin
                    e = exp_prp_q.pop_front();
                    chk("propagate", 32'(pk(i, s_propagate_data)), 32'(e));
                end
            end
        end
        @(posedge clock);
        #1;
        s_argument_valid = s_argument_valid & ~(ahs & ~keep);
        s_error_valid    = s_error_valid & ~ehs;
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain(input string tag, input int budget);
        int left;
        left = budget;
        while ((exp_res_q.size() != 0 || exp_prp_q.size() != 0) && left > 0) begin
            step();
            left--;
        end
        chk({tag, "_drain"}, 32'(exp_res_q.size() + exp_prp_q.size()), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({s_argument_ready, s_result_valid, s_error_ready, s_propagate_valid,
                      m_argument_valid, m_result_ready, m_error_valid, m_propagate_ready,
                      m_train}), 32'd0);
    endtask

    logic [15:0] t3_arg [4];
    logic [7:0]  t3_res [4];

    // ---------------- directed sequence ----------------
    initial begin
        int left;
        t3_arg = '{16'h0000, 16'h0100, 16'hFF00, 16'h0400};
        t3_res = '{8'h80, 8'hC0, 8'h40, 8'hFF};
        n_cmp = 0; n_bad = 0; cyc = 0; keep = '0;
        reset = 1'b1; train = 1'b0;
        s_argument_valid = '0; s_argument_data = '0;
        s_error_valid = '0; s_error_data = '0;
        s_result_ready = '1; s_propagate_ready = '1;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_state", 32'(debug_state), 32'(IDLE));
        chk("rst_ptr", 32'(debug_ptr), 32'd0);
        chk("rst_grant", 32'(debug_grant), 32'd0);
        chk_quiet("rst_outputs");
        reset = 1'b0;

        // 1: single requester 2, inference, argument 0x0000
        s_argument_valid[2] = 1'b1;
        s_argument_data[32 +: 16] = 16'h0000;
        exp_res_q.push_back(pk(2, 16'h0080));
        step();
        chk("t1_state", 32'(debug_state), 32'(FWD));
        chk("t1_grant", 32'(debug_grant), 32'd2);
        chk("t1_m_arg_valid", 32'(m_argument_valid), 32'd1);
        chk("t1_s_arg_ready", 32'(s_argument_ready), 32'b0100);
        chk("t1_m_train", 32'(m_train), 32'd0);
        step();
        chk("t1_res_valid", 32'(s_result_valid), 32'b0100);
        chk("t1_arg_once", 32'(m_argument_valid), 32'd0);
        chk("t1_no_err", 32'(m_error_valid), 32'd0);
        step();
        chk("t1_idle", 32'(debug_state), 32'(IDLE));
        chk("t1_ptr", 32'(debug_ptr), 32'd3);
        chk_quiet("t1_quiet");
        chk("t1_drained", 32'(exp_res_q.size()), 32'd0);

        // 2: training, requester 0, argument 0x0000, error 0x0100
        train = 1'b1;
        s_argument_valid[0] = 1'b1;
        s_argument_data[15:0] = 16'h0000;
        s_error_valid[0] = 1'b1;
        s_error_data[15:0] = 16'h0100;
        exp_res_q.push_back(pk(0, 16'h0080));
        exp_prp_q.push_back(pk(0, 16'h0040));
        step();
        chk("t2_grant", 32'(debug_grant), 32'd0);
        chk("t2_m_train_fwd", 32'(m_train), 32'd1);
        chk("t2_err_held_fwd", 32'({s_error_ready, m_error_valid}), 32'd0);
        step();
        chk("t2_m_train_res", 32'(m_train), 32'd1);
        step();
        chk("t2_bwd", 32'(debug_state), 32'(BWD));
        chk("t2_err_ready", 32'(s_error_ready), 32'b0001);
        chk("t2_m_err", 32'({m_error_valid, m_error_data}), 32'h10100);
        train = 1'b0;
        step();
        chk("t2_m_train_bwd", 32'(m_train), 32'd1);
        chk("t2_prp_valid", 32'(s_propagate_valid), 32'b0001);
        step();
        chk("t2_idle", 32'(debug_state), 32'(IDLE));
        chk("t2_ptr", 32'(debug_ptr), 32'd1);
        chk("t2_m_train_idle", 32'(m_train), 32'd0);
        chk("t2_drained", 32'(exp_res_q.size() + exp_prp_q.size()), 32'd0);

        // Reset pulse so the round-robin test starts from ptr 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r2_ptr", 32'(debug_ptr), 32'd0);

        // 3: all four requesters continuously, 8 transactions
        grant_log.delete();
        hs_cyc.delete();
        keep = '1;
        for (int i = 0; i < N; i++) s_argument_data[16*i +: 16] = t3_arg[i];
        s_argument_valid = '1;
        for (int k = 0; k < 8; k++) exp_res_q.push_back(pk(k % 4, {8'h00, t3_res[k % 4]}));
        left = 60;
        while (grant_log.size() < 8 && left > 0) begin
            step();
            left--;
        end
        s_argument_valid = '0;
        keep = '0;
        chk("t3_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) chk("t3_order", 32'(grant_log[k]), 32'(k % 4));
            if (k > 0 && k < hs_cyc.size()) chk("t3_gap", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd3);
        end
        drain("t3", 10);

        // 4/6: requesters 1 and 3, result stall on requester 1, requester 2
        // waving an error that must be ignored
        s_result_ready[1] = 1'b0;
        s_argument_valid[1] = 1'b1;
        s_argument_data[16 +: 16] = 16'h0600;
        s_argument_valid[3] = 1'b1;
        s_argument_data[48 +: 16] = 16'hF9FF;
        s_error_valid[2] = 1'b1;
        s_error_data[32 +: 16] = 16'h1234;
        exp_res_q.push_back(pk(1, 16'h00FF));
        exp_res_q.push_back(pk(3, 16'h0000));
        step();
        chk("t4_grant", 32'(debug_grant), 32'd1);
        chk("t4_arg_ready", 32'(s_argument_ready), 32'b0010);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_valid", 32'(s_result_valid), 32'b0010);
            chk("t4_stall_data", 32'(s_result_data), 32'h00FF);
            chk("t4_stall_mready", 32'(m_result_ready), 32'd0);
            chk("t4_other_ready", 32'({s_argument_ready, s_error_ready, m_error_valid}), 32'd0);
            step();
        end
        s_result_ready[1] = 1'b1;
        step();
        chk("t4_gap_idle", 32'(debug_state), 32'(IDLE));
        chk("t4_ptr", 32'(debug_ptr), 32'd2);
        step();
        chk("t4_grant3", 32'(debug_grant), 32'd3);
        chk("t4_err_ignored", 32'(s_error_ready), 32'd0);
        drain("t4", 10);
        s_error_valid[2] = 1'b0;

        // 5: reset while a propagate is pending
        train = 1'b1;
        s_propagate_ready[2] = 1'b0;
        s_argument_valid[2] = 1'b1;
        s_argument_data[32 +: 16] = 16'h0000;
        s_error_valid[2] = 1'b1;
        s_error_data[32 +: 16] = 16'h0100;
        exp_res_q.push_back(pk(2, 16'h0080));
        step();
        step();
        step();
        chk("t5_bwd", 32'(debug_state), 32'(BWD));
        step();
        chk("t5_prp_pending", 32'(s_propagate_valid), 32'b0100);
        reset = 1'b1;
        step();
        chk_quiet("t5_after_reset");
        chk("t5_ptr", 32'(debug_ptr), 32'd0);
        chk("t5_state", 32'(debug_state), 32'(IDLE));
        reset = 1'b0;
        train = 1'b0;
        s_propagate_ready = '1;
        s_argument_valid[1] = 1'b1;
        s_argument_data[16 +: 16] = 16'h0000;
        exp_res_q.push_back(pk(1, 16'h0080));
        step();
        chk("t5_regrant", 32'(debug_grant), 32'd1);
        chk("t5_regrant_ready", 32'(s_argument_ready), 32'b0010);
        drain("t5", 10);
        step();
        chk_quiet("final_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_activation_arbiter
